keypad_scan_4x4: RTL

- Input-side counterpart of the multiplexed 7-segment display driver. That driver scans digit-select lines outward; this block scans a 4x4 matrix keypad inward.
- It drives one column low at a time and samples the four row lines. It debounces both press and release.
- For each accepted key it emits one 4-bit key code with a single-cycle valid pulse.
- The irrigation controller's setpoint/menu logic uses it to enter values and commands shown on the display.

---
 rtl/keypad_scan_4x4.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: scans a 4x4 matrix keypad one column at a time (one-cold
// drive), synchronizes the row returns, debounces press and release, and
// emits a 4-bit key code {row, col} with a single-cycle valid pulse.
module keypad_scan_4x4 #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned CNT_W          = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_rows,
  output logic [3:0] o_cols,
  output logic [3:0] o_key,
  output logic       o_key_valid,
  output logic       o_key_held,
  output logic       o_multi_key
);

  // Debounce counter only ever needs to reach DEBOUNCE_TICKS-1: the final
  // matching tick is acted on directly so KeyValid lands one cycle after it.
  localparam int unsigned DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_sync1;
  logic [3:0]       r_rs;
  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_col;
  logic [3:0]       r_cand;
  logic [DB_W-1:0]  r_db_cnt;

  logic             w_tick;
  logic [3:0]       w_low;
  logic             w_none;
  logic             w_single;
  logic [1:0]       w_row_idx;
  logic [1:0]       w_col_nxt;
  logic [3:0]       w_cols_nxt;
  logic             w_same_row;
  logic             w_cand_high;

  // Two-flop synchronizer for the asynchronous row lines (idle = pulled up).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 4'b1111;
      r_rs    <= 4'b1111;
    end else begin
      r_sync1 <= i_rows;
      r_rs    <= r_sync1;
    end
  end

  // Free-running column-slot prescaler; tick marks the last cycle of a slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (r_presc == PRE_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == PRE_LAST);

  // Row decode of the synchronized sample: none / exactly one / several low.
  always_comb begin
    w_low     = ~r_rs;
    w_none    = (r_rs == 4'b1111);
    w_single  = !w_none && ((w_low & (w_low - 4'd1)) == 4'd0);
    w_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_rs[i]) w_row_idx = i[1:0];
    end
  end

  assign w_col_nxt   = r_col + 2'd1;
  assign w_cols_nxt  = ~(4'b0001 << w_col_nxt);
  assign w_same_row  = w_single && (w_row_idx == r_cand[3:2]);
  assign w_cand_high = r_rs[r_cand[3:2]];

  // Scan / debounce / held controller with registered outputs; the column
  // only moves on a tick, so Cols stays one-cold through every transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_SCAN;
      r_col       <= 2'd0;
      o_cols      <= 4'b1110;
      r_cand      <= 4'd0;
      r_db_cnt    <= '0;
      o_key       <= 4'd0;
      o_key_valid <= 1'b0;
      o_key_held  <= 1'b0;
      o_multi_key <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      o_multi_key <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_none) begin
              r_col  <= w_col_nxt;
              o_cols <= w_cols_nxt;
            end else if (w_single) begin
              r_cand   <= {w_row_idx, r_col};
              r_db_cnt <= '0;
              r_state  <= S_DEBOUNCE;
            end else begin
              o_multi_key <= 1'b1;
              r_col       <= w_col_nxt;
              o_cols      <= w_cols_nxt;
            end
          end
          S_DEBOUNCE: begin
            if (w_same_row) begin
              if (r_db_cnt == DB_LAST) begin
                o_key       <= r_cand;
                o_key_valid <= 1'b1;
                o_key_held  <= 1'b1;
                r_db_cnt    <= '0;
                r_state     <= S_HELD;
              end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
              end
            end else begin
              r_state <= S_SCAN;
              r_col   <= w_col_nxt;
              o_cols  <= w_cols_nxt;
            end
          end
          S_HELD: begin
            // Only the captured row matters here; other keys are ignored.
            if (w_cand_high) begin
              if (r_db_cnt == DB_LAST) begin
                o_key_held <= 1'b0;
                r_db_cnt   <= '0;
                r_state    <= S_SCAN;
                r_col      <= w_col_nxt;
                o_cols     <= w_cols_nxt;
              end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
              end
            end else begin
              r_db_cnt <= '0;
            end
          end
          default: begin
            r_state <= S_SCAN;
          end
        endcase
      end
    end
  end

endmodule
